// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencer and its helpers.
package booth_pkg;

  // Sequencer phases: wait for a request, clear the multiplier, let it run, return the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 16;

  // Width of a full signed product of two w-bit operands.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Search ptr+1, ptr+2, ... modulo NUM_REQ and take the first pending request.
  always_comb begin : p_search
    logic [ID_W-1:0] idx;
    logic            found;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one iterative signed Booth multiplier among NUM_REQ requesters.
// Round-robin grant, clear/run sequencing, watchdog abort, single response channel.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  output logic                         mul_clear,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  input  logic [prod_w(WIDTH)-1:0]     mul_p,
  input  logic                         mul_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [prod_w(WIDTH)-1:0]     rsp_p,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int P_W   = prod_w(WIDTH);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CLEAR = CLEAR;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_RESP  = RESP;

  logic [1:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   wd_cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               arb_en;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Grants are only offered while idle and never while reset is held, so req_ready reads 0 in reset.
  assign arb_en = (state == S_IDLE) && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (ptr),
    .enable   (arb_en),
    .grant    (gnt),
    .grant_id (gnt_id)
  );

  assign req_ready = gnt;
  assign sel_a     = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b     = req_b[int'(gnt_id)*WIDTH +: WIDTH];

  // Multiplier controls and status decode straight from the phase.
  assign mul_clear = (state == S_CLEAR);
  assign mul_start = (state == S_RUN);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // Sequencer: grant and latch, one-cycle clear, run under watchdog, hold response until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
      state   <= S_IDLE;
      ptr     <= ID_W'(NUM_REQ - 1);
      wd_cnt  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rsp_id  <= '0;
      rsp_p   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            rsp_id <= gnt_id;
            ptr    <= gnt_id;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          wd_cnt <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A completion on the last allowed cycle still counts as a success.
          if (mul_ready) begin
            rsp_p   <= mul_p;
            rsp_err <= 1'b0;
            state   <= S_RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_p   <= P_W'(0);
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative signed Booth multiplier among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Clears the multiplier and holds start and operands until the multiplier reports ready.
- Returns the product and requester ID on one shared response channel.
- A watchdog aborts runs that never complete.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 4, signed operand width; product is 2*WIDTH
TIMEOUT, 16, max RUN cycles before abort (>=2)
(localparam ID_W = $clog2(NUM_REQ))

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot accept strobe
req_a  in  NUM_REQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  multipliers, same packing
mul_clear  out  1  one-cycle clear to the multiplier's reset
mul_start  out  1  multiplier start, held through RUN
mul_a  out  WIDTH  latched multiplicand
mul_b  out  WIDTH  latched multiplier
mul_p  in  2*WIDTH  multiplier product
mul_ready  in  1  multiplier done
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  granted requester index
rsp_p  out  2*WIDTH  signed product (0 on error)
rsp_err  out  1  watchdog abort flag
busy  out  1  high in any state except IDLE

Behaviour:
- Reset value of every output is 0. This includes req_ready, mul_*, rsp_*, and busy. The state goes to IDLE and the RR pointer goes to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation abandons the transaction with no response.
- The FSM has four states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - If any req_valid bit is set, grant g = the first set bit searching from ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle. Latch req_a[g], req_b[g] and g, set ptr<=g, and go to CLEAR.
  - Only one grant is issued per transaction. Non-granted requesters hold valid and wait.
- CLEAR: mul_clear=1 for exactly one cycle, mul_start=0, then go to RUN. Clear the watchdog count to 0.
- RUN:
  - mul_start=1, with mul_a/mul_b driven from the latches and stable throughout. The count increments every cycle.
  - If mul_ready=1, capture mul_p into rsp_p, set rsp_err=0, go to RESP.
  - Otherwise, if count==TIMEOUT-1, set rsp_p=0, rsp_err=1, go to RESP.
  - mul_ready wins when it coincides with the timeout.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_p/rsp_err stable. mul_start=0.
  - When rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
  - A new grant is possible in the cycle after the return to IDLE.
- Back-to-back throughput: one transaction per 3+N cycles, where N is the multiplier run length, plus response stall.
- mul_ready is ignored outside RUN.
- Accept latency (req_valid seen in IDLE to mul_start high): 2 cycles.
- Fairness: a requester with valid held continuously is granted within NUM_REQ transactions.
- Arithmetic: the block does no math. rsp_p is the raw 2*WIDTH signed product passed through unchanged.
- req_valid dropping while the block is not idle has no effect. Accepted operands are already latched.

Decomposition:
- Shared package booth_pkg holds:
  - the state enum typedef (IDLE/CLEAR/RUN/RESP);
  - the default WIDTH and TIMEOUT constants;
  - a function prod_w(w)=2*w.
- One natural sub-module: rr_arbiter. Inputs are req vector, ptr and enable; outputs are the one-hot grant and its encoded index. It is reusable by other shared datapaths.
- The watchdog counter and the FSM stay in the top.

Test Plan:
- Bench multiplier model: reference product with mul_ready after 3 RUN cycles unless noted.
- Single request, req0 a=3, b=-2 (4'hE) -> req_ready[0] pulse, then mul_clear for 1 cycle, then mul_start with mul_a=3, mul_b=E; response rsp_id=0, rsp_p=8'hFA, rsp_err=0.
- All four valid simultaneously after reset, with a/b = (1,1), (2,2), (-1,3), (-8,-8) -> grants in order 0,1,2,3; rsp_p = 8'h01, 8'h04, 8'hFD, 8'h40.
- Fairness: req0 held valid continuously plus req2 -> grants alternate 0,2,0,2. Then req1 alone -> granted next.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_id/rsp_p stay stable; no new req_ready until the handshake completes.
- Watchdog: model never asserts mul_ready, TIMEOUT=16 -> exactly 16 mul_start cycles, then rsp_err=1, rsp_p=0. mul_ready arriving on the 16th RUN cycle -> rsp_err=0 with the valid product.
- Reset asserted during RUN -> next cycle all outputs are 0, no response is produced; the following request from req1 gets a clean CLEAR/RUN sequence.
